// File: rtl/div_iter.sv
// Iterative restoring divider, signed or unsigned, one quotient bit per clock.
// Operands are reduced to magnitudes on entry; signs are reapplied when results are registered.
module div_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_div,
   input  logic             annul,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   // Partial remainder stays below the divisor, so its top (sign) bit is always zero and not kept.
   logic [WIDTH-1:0]  p_q, p_d;
   logic [WIDTH-1:0]  q_q, q_d;
   logic [WIDTH-1:0]  dvd_q, dvd_d;
   logic [WIDTH-1:0]  dvs_q, dvs_d;
   logic              qneg_q, qneg_d;
   logic              rneg_q, rneg_d;
   logic              dz_q, dz_d;
   logic [WIDTH-1:0]  quotient_q, quotient_d;
   logic [WIDTH-1:0]  remainder_q, remainder_d;
   logic              div_zero_q, div_zero_d;
   logic              done_q, done_d;

   logic [WIDTH-1:0]  dvd_abs;
   logic [WIDTH-1:0]  dvs_abs;
   logic [WIDTH:0]    shifted;
   logic [WIDTH:0]    trial;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      p_d         = p_q;
      q_d         = q_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      dz_d        = dz_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      done_d      = 1'b0;

      dvd_abs = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
      dvs_abs = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;
      shifted = {p_q, dvd_q[cnt_q]};
      trial   = shifted - {1'b0, dvs_q};

      unique case (state_q)
         StIdle: begin
            if (start && !annul) begin
               qneg_d = signed_div && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               rneg_d = signed_div && dividend[WIDTH-1];
               p_d    = '0;
               q_d    = '0;
               cnt_d  = CntW'(WIDTH - 1);
               if (divisor == '0) begin
                  // Raw dividend is kept so it can be returned unmodified as the remainder.
                  dz_d    = 1'b1;
                  dvd_d   = dividend;
                  dvs_d   = '0;
                  state_d = StDone;
               end else begin
                  dz_d    = 1'b0;
                  dvd_d   = dvd_abs;
                  dvs_d   = dvs_abs;
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            if (annul) begin
               state_d = StIdle;
            end else begin
               if (!trial[WIDTH]) begin
                  p_d        = trial[WIDTH-1:0];
                  q_d[cnt_q] = 1'b1;
               end else begin
                  p_d = shifted[WIDTH-1:0];
               end
               if (cnt_q == '0) begin
                  state_d = StDone;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         StDone: begin
            if (annul) begin
               state_d = StIdle;
            end else begin
               state_d = StIdle;
               done_d  = 1'b1;
               if (dz_q) begin
                  quotient_d  = '1;
                  remainder_d = dvd_q;
                  div_zero_d  = 1'b1;
               end else begin
                  // Most-negative / -1 wraps back to most-negative here with no extra logic.
                  quotient_d  = qneg_q ? -q_q : q_q;
                  remainder_d = rneg_q ? -p_q : p_q;
                  div_zero_d  = 1'b0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         p_q         <= '0;
         q_q         <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         dz_q        <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         p_q         <= p_d;
         q_q         <= q_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         dz_q        <= dz_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
         done_q      <= done_d;
      end
   end

   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;

endmodule
